// File: rtl/ysyx_22040365_pkg.sv
// Shared widths and load funct3 encodings for the writeback unit.
package ysyx_22040365_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
endpackage

// File: rtl/ysyx_22040365_load_ext.sv
// Load byte-select and sign/zero extension from a raw aligned 64-bit word.
// Purely combinational; no handshake of its own.
module ysyx_22040365_load_ext
  import ysyx_22040365_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  // Logical shift: bytes past the top of the word come in as zero.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      LB:      data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      data = {{32{shifted[31]}}, shifted[31:0]};
      LD:      data = shifted;
      LBU:     data = {56'd0, shifted[7:0]};
      LHU:     data = {48'd0, shifted[15:0]};
      LWU:     data = {32'd0, shifted[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040365_wbu.sv
// Writeback unit: LSU-first arbitration, registered regfile write, busy scoreboard, counter.
// Latency 1 cycle; LSU always accepted out of reset, EXU stalls while lsu_valid is high.
module ysyx_22040365_wbu
  import ysyx_22040365_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREG       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [2:0]            lsu_addr_lo,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [63:0]           wb_cnt
);

  logic                  lsu_fire;
  logic                  exu_fire;
  logic                  any_fire;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] load_data;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;

  ysyx_22040365_load_ext u_load_ext (
    .rdata   (lsu_rdata),
    .addr_lo (lsu_addr_lo),
    .funct3  (lsu_funct3),
    .data    (load_data)
  );

  assign lsu_ready = rst_n;
  assign exu_ready = rst_n & ~lsu_valid;
  assign lsu_fire  = lsu_valid & lsu_ready;
  assign exu_fire  = exu_valid & exu_ready;
  assign any_fire  = lsu_fire | exu_fire;
  assign sel_rd    = lsu_fire ? lsu_rd : exu_rd;
  assign sel_data  = lsu_fire ? load_data : exu_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_cnt   <= '0;
    end else begin
      rf_wen <= any_fire && (sel_rd != '0);
      if (any_fire) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
        wb_cnt   <= wb_cnt + 64'd1;
      end
    end
  end

  // Clear tracks the regfile write edge; a same-cycle issue is a newer producer and wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen)
      busy_nxt[rf_waddr] = 1'b0;
    if (issue_valid && issue_wen && (issue_rd != '0))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign rs1_busy = busy[chk_rs1];
  assign rs2_busy = busy[chk_rs2];

endmodule
